// File: rtl/pipe_pkg.sv
// Shared types and default sizing for the operand pipeline stage with skid buffer.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned NUM_CH_DEF = 3;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy state machine for the skid stage; owns the registered in_ready.
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load_main,
    output logic load_skid,
    output logic skid_to_main
);

    pipe_state_e state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        accept;

    always_comb begin
        accept       = in_valid && in_ready_q;
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (accept && out_ready) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    skid_to_main = 1'b1;
                    state_d      = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any transfer decided above.
        if (flush) begin
            state_d      = EMPTY;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);

endmodule

// File: rtl/pipe_stage_skid.sv
// Operand pipeline stage: main + skid register pair with a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int unsigned BeatW = NUM_CH * DATA_W;

    logic [BeatW-1:0] main_q, skid_q;
    logic [CNT_W-1:0] stall_q;
    logic             load_main, load_skid, skid_to_main;

    pipe_skid_ctrl u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .load_main    (load_main),
        .load_skid    (load_skid),
        .skid_to_main (skid_to_main)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_data;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    // Counts stalled cycles independently of flush; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign out_data  = main_q;
    assign stall_cnt = stall_q;

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter NUM_CH, default 3: number of operand channels carried through the stage.
REQ-002 Parameter DATA_W, default 32: width of each channel in bits.
REQ-003 Parameter CNT_W, default 16: width of the stall counter in bits.
REQ-004 clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous squash of all stage contents.
REQ-007 in_valid  input  1  upstream holds a valid beat.
REQ-008 in_data  input  NUM_CH x DATA_W  upstream operand channels (e.g. regA, regB, ext).
REQ-009 in_ready  output  1  stage accepts a beat this cycle; registered.
REQ-010 out_valid  output  1  stage presents a valid beat.
REQ-011 out_data  output  NUM_CH x DATA_W  operand channels to execute.
REQ-012 out_ready  input  1  downstream consumes the beat this cycle.
REQ-013 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 A transfer in SHALL occur when in_valid=1 and in_ready=1; a transfer out SHALL occur when out_valid=1 and out_ready=1.
REQ-015 Latency: a beat accepted at edge N SHALL appear on out_data/out_valid after edge N, unchanged, when the stage was EMPTY or draining.
REQ-016 Storage: one main register (drives out_data) and one skid register, each NUM_CH x DATA_W.
REQ-017 State EMPTY: out_valid=0, in_ready=1; in_valid -> load main, go BUSY.
REQ-018 State BUSY: out_valid=1, in_ready=1.
- in_valid and out_ready -> load main, stay BUSY.
- in_valid and not out_ready -> load skid, go FULL.
- not in_valid and out_ready -> EMPTY.
- neither -> hold.
REQ-019 State FULL: out_valid=1, in_ready=0; out_ready -> copy skid to main, go BUSY; else hold.
REQ-020 in_ready SHALL be driven from a flop: 1 in EMPTY and BUSY, 0 in FULL; it has no combinational path from out_ready.
REQ-021 No beat SHALL be dropped, duplicated or reordered absent flush.
REQ-022 flush=1 SHALL force EMPTY on the next edge, regardless of in_valid/out_ready. It overrides any simultaneous transfer. The beat offered that cycle is discarded. Data registers may retain stale values.
REQ-023 out_data SHALL hold its value whenever out_valid=1 and out_ready=0.
REQ-024 stall_cnt SHALL increment by 1 per cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and not be cleared by flush.

Reset
REQ-025 rst_n=0 SHALL immediately force state EMPTY, out_valid=0, in_ready=0, out_data=0, skid=0 and stall_cnt=0.
REQ-026 The first rising edge after rst_n deasserts SHALL set in_ready=1. Reset asserted mid-transfer SHALL discard all held beats.

Structure
REQ-027 Package pipe_pkg SHALL hold the state enum (EMPTY, BUSY, FULL) and default constants for NUM_CH, DATA_W and CNT_W.
REQ-028 One sub-module, pipe_skid_ctrl, SHALL hold the state machine and the in_ready flop. The datapath registers and stall counter live in pipe_stage_skid.

Verification
REQ-029 Streaming: out_ready=1, drive beats A=1,2,3 then B=4,5,6 on consecutive cycles -> each appears 1 cycle later, in_ready stays 1, stall_cnt=0.
REQ-030 Backpressure: BUSY with beat 1, out_ready=0, offer beat 2 -> FULL, in_ready=0 next cycle. Release out_ready -> beat 1 then beat 2 out, no loss.
REQ-031 Stall count: out_valid=1, out_ready=0 held 5 cycles -> stall_cnt=5; with CNT_W=3 held 10 cycles -> stall_cnt=7.
REQ-032 Flush in FULL with in_valid=1 and out_ready=1 -> EMPTY next edge, out_valid=0, offered beat never emerges.
REQ-033 Async reset: assert rst_n=0 between edges while FULL -> out_valid, in_ready, out_data and stall_cnt go 0 without a clock edge; in_ready=1 after the first edge post-release.
REQ-034 Parameter sweep: NUM_CH=1/DATA_W=8 and NUM_CH=4/DATA_W=64 -> random valid/ready scoreboard, zero mismatches over 10k beats.
